// File: rtl/evm_pkg.sv
// Shared definitions for the EVM session controller and vote datapath:
// session states, default widths and the one-hot selection check.
package evm_pkg;

  localparam int unsigned NUM_PARTY_DEF = 3;
  localparam int unsigned CNT_W_DEF     = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPEN   = 3'd1,
    ST_ARMED  = 3'd2,
    ST_CAST   = 3'd3,
    ST_CLOSED = 3'd4
  } state_t;

  // True when exactly one bit is set; callers zero-extend narrower selections.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/evm_ballot_timer.sv
// Loadable down-counter that holds at zero and flags it; times out an armed ballot.
module evm_ballot_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/evm_session_ctrl.sv
// Polling-session sequencer: opens/closes the poll, arms one ballot per
// authorisation and turns a qualified voter press into a one-cycle party increment.
module evm_session_ctrl
  import evm_pkg::*;
#(
  parameter int unsigned NUM_PARTY   = NUM_PARTY_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 open_poll,
  input  logic                 close_poll,
  input  logic                 ballot_auth,
  input  logic                 vote_btn,
  input  logic [NUM_PARTY-1:0] vote_sel,
  output logic                 start_vote,
  output logic [NUM_PARTY-1:0] party_inc,
  output logic                 vote_accept,
  output logic                 vote_reject,
  output logic                 ballot_void,
  output logic                 poll_open,
  output logic                 poll_closed,
  output logic [CNT_W-1:0]     ballots_cast
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  state_t               r_state, w_next;
  logic [RW-1:0]        r_retry, w_retry, w_retry_inc;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic                 r_close_pend, w_close_pend;
  logic                 w_load, w_zero;
  logic [NUM_PARTY-1:0] w_party_inc, r_party_inc;
  logic                 w_accept, w_reject, w_void;
  logic                 r_accept, r_reject, r_void;
  logic                 r_start, r_open, r_closed;

  evm_ballot_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (TW'(TIMEOUT_CYC - 1)),
    .i_en       (r_state == ST_ARMED),
    .o_zero     (w_zero)
  );

  assign w_retry_inc = r_retry + RW'(1);

  always_comb begin
    w_next       = r_state;
    w_retry      = r_retry;
    w_cnt        = r_cnt;
    w_close_pend = r_close_pend;
    w_load       = 1'b0;
    w_party_inc  = '0;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_void       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (open_poll) w_next = ST_OPEN;
      end
      ST_OPEN: begin
        if (close_poll || r_close_pend) begin
          w_next = ST_CLOSED;
        end else if (ballot_auth) begin
          w_next  = ST_ARMED;
          w_load  = 1'b1;
          w_retry = '0;
        end
      end
      ST_ARMED: begin
        if (close_poll) w_close_pend = 1'b1;
        // A press on the expiry cycle takes priority over the timeout.
        if (vote_btn) begin
          if (is_onehot(32'(vote_sel))) begin
            w_next      = ST_CAST;
            w_party_inc = vote_sel;
            w_accept    = 1'b1;
            w_cnt       = r_cnt + CNT_W'(1);
          end else begin
            w_reject = 1'b1;
            w_retry  = w_retry_inc;
            if (w_retry_inc == RW'(MAX_RETRY)) begin
              w_void = 1'b1;
              w_next = ST_OPEN;
            end
          end
        end else if (w_zero) begin
          w_void = 1'b1;
          w_next = ST_OPEN;
        end
      end
      ST_CAST: begin
        if (close_poll) w_close_pend = 1'b1;
        // ballots_cast already holds the incremented value; close at full scale.
        if (r_close_pend || (r_cnt == '1)) w_next = ST_CLOSED;
        else                               w_next = ST_OPEN;
      end
      ST_CLOSED: w_next = ST_CLOSED;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_retry      <= '0;
      r_cnt        <= '0;
      r_close_pend <= 1'b0;
      r_party_inc  <= '0;
      r_accept     <= 1'b0;
      r_reject     <= 1'b0;
      r_void       <= 1'b0;
      r_start      <= 1'b0;
      r_open       <= 1'b0;
      r_closed     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_retry      <= w_retry;
      r_cnt        <= w_cnt;
      r_close_pend <= w_close_pend;
      r_party_inc  <= w_party_inc;
      r_accept     <= w_accept;
      r_reject     <= w_reject;
      r_void       <= w_void;
      r_start      <= (w_next == ST_ARMED);
      r_open       <= (w_next == ST_OPEN) || (w_next == ST_ARMED) || (w_next == ST_CAST);
      r_closed     <= (w_next == ST_CLOSED);
    end
  end

  assign start_vote   = r_start;
  assign party_inc    = r_party_inc;
  assign vote_accept  = r_accept;
  assign vote_reject  = r_reject;
  assign ballot_void  = r_void;
  assign poll_open    = r_open;
  assign poll_closed  = r_closed;
  assign ballots_cast = r_cnt;

endmodule

// File: tb/tb_evm_session_ctrl.sv
// Self-checking bench for evm_session_ctrl: per-cycle vector table with a
// scoreboard queue, plus hand-written reset and counter-saturation sequences.
module tb_evm_session_ctrl;

  localparam int unsigned NP = 3;
  localparam int unsigned CW = 3;
  localparam int unsigned TO = 8;
  localparam int unsigned MR = 3;

  typedef struct packed {
    logic       open, close, auth, btn;
    logic [2:0] sel;
  } in_t;

  typedef struct packed {
    logic       sv, po, pc;
    logic [2:0] pinc;
    logic       acc, rej, vd;
    logic [2:0] cast;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          open_poll, close_poll, ballot_auth, vote_btn;
  logic [NP-1:0] vote_sel;
  logic          start_vote, vote_accept, vote_reject, ballot_void, poll_open, poll_closed;
  logic [NP-1:0] party_inc;
  logic [CW-1:0] ballots_cast;

  always #5 clk = ~clk;

  evm_session_ctrl #(
    .NUM_PARTY   (NP),
    .CNT_W       (CW),
    .TIMEOUT_CYC (TO),
    .MAX_RETRY   (MR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .open_poll    (open_poll),
    .close_poll   (close_poll),
    .ballot_auth  (ballot_auth),
    .vote_btn     (vote_btn),
    .vote_sel     (vote_sel),
    .start_vote   (start_vote),
    .party_inc    (party_inc),
    .vote_accept  (vote_accept),
    .vote_reject  (vote_reject),
    .ballot_void  (ballot_void),
    .poll_open    (poll_open),
    .poll_closed  (poll_closed),
    .ballots_cast (ballots_cast)
  );

  vec_t        vecs[$];
  out_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic in_t inp(input logic o, c, a, b, input logic [2:0] s);
    in_t r;
    r.open = o; r.close = c; r.auth = a; r.btn = b; r.sel = s;
    return r;
  endfunction

  function automatic out_t st(input logic sv, po, pc, input logic [2:0] c);
    out_t r;
    r = '0;
    r.sv = sv; r.po = po; r.pc = pc; r.cast = c;
    return r;
  endfunction

  function automatic out_t st_open(input logic [2:0] c);   return st(1'b0, 1'b1, 1'b0, c); endfunction
  function automatic out_t st_armed(input logic [2:0] c);  return st(1'b1, 1'b1, 1'b0, c); endfunction
  function automatic out_t st_closed(input logic [2:0] c); return st(1'b0, 1'b0, 1'b1, c); endfunction

  function automatic out_t f_acc(input out_t o, input logic [2:0] p);
    o.acc = 1'b1; o.pinc = p;
    return o;
  endfunction
  function automatic out_t f_rej(input out_t o);  o.rej = 1'b1; return o; endfunction
  function automatic out_t f_void(input out_t o); o.vd  = 1'b1; return o; endfunction

  function automatic out_t actual();
    out_t r;
    r.sv = start_vote; r.po = poll_open; r.pc = poll_closed; r.pinc = party_inc;
    r.acc = vote_accept; r.rej = vote_reject; r.vd = ballot_void; r.cast = ballots_cast;
    return r;
  endfunction

  function automatic void add(input in_t i, input out_t o);
    vec_t v;
    v.i = i; v.o = o;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input out_t got, input out_t exp, input string nm, input int tag);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got sv/po/pc/pinc/acc/rej/vd/cast=%b/%b/%b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%b/%b/%0d",
               nm, tag, got.sv, got.po, got.pc, got.pinc, got.acc, got.rej, got.vd, got.cast,
               exp.sv, exp.po, exp.pc, exp.pinc, exp.acc, exp.rej, exp.vd, exp.cast);
    end
  endtask

  // Called at a negedge: drive inputs, expect outputs one cycle later.
  task automatic step(input in_t i, input out_t o, input string nm, input int tag);
    open_poll   = i.open;
    close_poll  = i.close;
    ballot_auth = i.auth;
    vote_btn    = i.btn;
    vote_sel    = i.sel;
    exp_q.push_back(o);
    @(negedge clk);
    cmp(actual(), exp_q.pop_front(), nm, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    open_poll = 1'b0; close_poll = 1'b0; ballot_auth = 1'b0; vote_btn = 1'b0; vote_sel = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t nop;
    logic [2:0] p;
    nop = inp(0, 0, 0, 0, 3'b000);

    rst_n = 1'b0;
    open_poll = 1'b0; close_poll = 1'b0; ballot_auth = 1'b0; vote_btn = 1'b0; vote_sel = '0;
    repeat (3) @(negedge clk);
    cmp(actual(), '0, "reset", 0);
    rst_n = 1'b1;

    // Single valid vote, ignored press in OPEN
    add(inp(1, 0, 0, 0, 3'b000), st_open(0));
    add(inp(0, 0, 0, 1, 3'b001), st_open(0));
    add(inp(0, 0, 1, 0, 3'b000), st_armed(0));
    add(inp(0, 0, 0, 1, 3'b010), f_acc(st_open(1), 3'b010));
    add(nop,                     st_open(1));
    // Retries exhausted: multi-hot, zero, multi-hot
    add(inp(0, 0, 1, 0, 3'b000), st_armed(1));
    add(inp(0, 0, 0, 1, 3'b011), f_rej(st_armed(1)));
    add(inp(0, 0, 0, 1, 3'b000), f_rej(st_armed(1)));
    add(inp(0, 0, 0, 1, 3'b011), f_void(f_rej(st_open(1))));
    add(nop,                     st_open(1));
    // Timeout: TO armed cycles, then void
    add(inp(0, 0, 1, 0, 3'b000), st_armed(1));
    for (int k = 1; k < int'(TO); k++) add(nop, st_armed(1));
    add(nop,                     f_void(st_open(1)));
    add(nop,                     st_open(1));
    // Press on the expiry cycle wins
    add(inp(0, 0, 1, 0, 3'b000), st_armed(1));
    for (int k = 1; k < int'(TO); k++) add(nop, st_armed(1));
    add(inp(0, 0, 0, 1, 3'b100), f_acc(st_open(2), 3'b100));
    add(nop,                     st_open(2));
    // close_poll while armed: ballot completes, then closed for good
    add(inp(0, 0, 1, 0, 3'b000), st_armed(2));
    add(inp(0, 1, 0, 0, 3'b000), st_armed(2));
    add(inp(0, 0, 0, 1, 3'b001), f_acc(st_open(3), 3'b001));
    add(nop,                     st_closed(3));
    add(inp(0, 0, 1, 0, 3'b000), st_closed(3));
    add(inp(0, 0, 0, 1, 3'b001), st_closed(3));
    add(inp(1, 0, 0, 0, 3'b000), st_closed(3));

    @(negedge clk);
    for (int n = 0; n < vecs.size(); n++) step(vecs[n].i, vecs[n].o, "vec", n);

    // Async reset mid-ballot, presses before open_poll, close beats auth
    do_reset();
    step(inp(0, 0, 0, 1, 3'b001), '0, "pre_open_btn", 0);
    step(inp(0, 0, 1, 0, 3'b000), '0, "pre_open_auth", 0);
    step(inp(1, 0, 0, 0, 3'b000), st_open(0), "rst_seq", 0);
    step(inp(0, 0, 1, 0, 3'b000), st_armed(0), "rst_seq", 1);
    ballot_auth = 1'b0;
    #2 rst_n = 1'b0;
    #1 cmp(actual(), '0, "async_rst", 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(inp(0, 0, 0, 1, 3'b001), '0, "post_rst_btn", 0);
    step(inp(1, 0, 0, 0, 3'b000), st_open(0), "post_rst", 0);
    step(nop,                     st_open(0), "post_rst", 1);
    step(inp(0, 1, 1, 0, 3'b000), st_closed(0), "close_beats_auth", 0);

    // Counter saturation at 2**CW-1
    do_reset();
    step(inp(1, 0, 0, 0, 3'b000), st_open(0), "sat_open", 0);
    for (int b = 1; b <= 7; b++) begin
      p = 3'b001 << (b % 3);
      step(inp(0, 0, 1, 0, 3'b000), st_armed(3'(b - 1)), "sat_arm", b);
      step(inp(0, 0, 0, 1, p), f_acc(st_open(3'(b)), p), "sat_cast", b);
      step(nop, (b == 7) ? st_closed(3'd7) : st_open(3'(b)), "sat_after", b);
    end
    step(inp(0, 0, 1, 0, 3'b000), st_closed(7), "sat_ignored", 0);
    step(inp(0, 0, 0, 1, 3'b010), st_closed(7), "sat_ignored", 1);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
